// File: rtl/periph_bus_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_pkg
// Shared definitions for the peripheral bus initiator:
//   - state_t       : initiator FSM states
//   - ADDR_W/DATA_W : bus address and data widths
//   - PORT_SEL_*    : address bits that select the peripheral port
//   - TMO_CNT_W     : width of the bus-wait timeout counter
// -----------------------------------------------------------------------------
package periph_bus_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned PORT_SEL_MSB = 31;
    localparam int unsigned PORT_SEL_LSB = 30;
    localparam int unsigned TMO_CNT_W    = 8;

    // IDLE : waiting for a host request (the only state with req_ready = 1)
    // ISSUE: one strobe-low cycle with address/data already on the bus
    // WAIT : strobe asserted until busReady (or timeout when enabled)
    // RESP : response held until the host takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Peripheral port selected by an address.
    function automatic logic [PORT_SEL_MSB-PORT_SEL_LSB:0] port_sel(input logic [ADDR_W-1:0] addr);
        return addr[PORT_SEL_MSB:PORT_SEL_LSB];
    endfunction

endpackage

// File: rtl/pbi_timeout_ctr.sv
// -----------------------------------------------------------------------------
// pbi_timeout_ctr
// Bus-wait counter used by periph_bus_initiator when PBI_TIMEOUT_EN is defined.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset (count -> 0)
//   clear  : synchronous clear, has priority over enable
//   enable : count one more wait cycle
//   tc     : terminal count; high in the cycle whose increment brings the
//            count to TERMINAL, so the owner can react on that same edge
// -----------------------------------------------------------------------------
module pbi_timeout_ctr
    import periph_bus_pkg::*;
#(
    parameter int unsigned WIDTH    = TMO_CNT_W,
    parameter int unsigned TERMINAL = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = enable && !clear && (count == LAST);

endmodule

// File: rtl/periph_bus_initiator.sv
// -----------------------------------------------------------------------------
// periph_bus_initiator
// Converts a host valid/ready request/response handshake into a simple
// peripheral bus cycle (read/write strobe held until busReady).
//
// Parameters
//   TIMEOUT_CYCLES : bus-wait cycles before abort (1..255), used only when
//                    the PBI_TIMEOUT_EN macro is defined
// Build option
//   PBI_TIMEOUT_EN : enables the bus-wait timeout; without it WAIT lasts until
//                    busReady and rsp_error is tied to 0
// Ports
//   clk, reset                       : clock and async active-low reset
//   req_valid/req_ready              : host request handshake
//   req_write, req_addr, req_wdata   : request payload
//   rsp_valid/rsp_ready              : host response handshake
//   rsp_rdata, rsp_error             : response payload
//   address, dataOut, dataIn         : peripheral bus address / data
//   read, write, busReady            : peripheral bus strobes and completion
// -----------------------------------------------------------------------------
module periph_bus_initiator
    import periph_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    // host request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // host response
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    // peripheral bus
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataOut,
    input  logic [DATA_W-1:0] dataIn,
    output logic              read,
    output logic              write,
    input  logic              busReady
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("periph_bus_initiator: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t state, state_next;
    logic   cap_write;
    logic   accept;
    logic   bus_done;
    logic   bus_timeout;

    // busReady only matters while a strobe is out.
    assign bus_done = (state == WAIT) && busReady;

`ifdef PBI_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;

    // ISSUE always precedes WAIT, so clearing there gives a fresh count on entry.
    assign tmo_clear  = (state == ISSUE);
    assign tmo_enable = (state == WAIT) && !busReady;

    pbi_timeout_ctr #(
        .WIDTH    (TMO_CNT_W),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .tc     (bus_timeout)
    );
`else
    assign bus_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus_done || bus_timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE first keeps acceptance one cycle after exit.
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // ------------------------------------------------------------------
    // Datapath. Strobes are registered from state_next so they rise on
    // entry to WAIT and fall on the edge that leaves it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_write <= 1'b0;
            address   <= '0;
            dataOut   <= '0;
            rsp_rdata <= '0;
            read      <= 1'b0;
            write     <= 1'b0;
        end else begin
            read  <= (state_next == WAIT) && !cap_write;
            write <= (state_next == WAIT) &&  cap_write;

            if (accept) begin
                cap_write <= req_write;
                address   <= req_addr;
                dataOut   <= req_write ? req_wdata : '0;
                rsp_rdata <= '0;
            end else if ((state == WAIT) && (state_next == RESP)) begin
                address <= '0;
                dataOut <= '0;
                // busReady takes priority over a coincident timeout.
                if (bus_done && !cap_write) begin
                    rsp_rdata <= dataIn;
                end else begin
                    rsp_rdata <= '0;
                end
            end
        end
    end

`ifdef PBI_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_error <= 1'b0;
        end else if (accept || bus_done) begin
            rsp_error <= 1'b0;
        end else if (bus_timeout) begin
            rsp_error <= 1'b1;
        end
    end
`else
    assign rsp_error = 1'b0;
`endif

endmodule
